// File: rtl/nibble_link_pkg.sv
// Shared definitions for the 4-bit nibble link, used by both the result
// transmitter and the instruction receiver.
package nibble_link_pkg;

  localparam int NIBBLE_W        = 4;
  localparam int NIBBLES_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    REQ     = 3'd2,
    RELEASE = 3'd3,
    DONE    = 3'd4
  } link_state_e;

endpackage

// File: rtl/nibble_link_sync.sv
// Multi-flop synchroniser for an asynchronous link strobe; clears to 0 on reset.
module nibble_link_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic q_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/nibble_result_tx.sv
// Serialises one PCPI result word LSB-nibble first over a four-phase req/ack link.
// Define NIBBLE_TX_CHECKSUM_EN to append an XOR checksum nibble after the data.
//
// state   | meaning
// IDLE    | waiting for a result word, res_ready high
// SETUP   | nibble on pins, waiting for ack_s low before raising req
// REQ     | tx_req high, waiting for host ack_s high
// RELEASE | tx_req low, waiting for host ack_s low
// DONE    | word complete, tx_done high for this one cycle
module nibble_result_tx
  import nibble_link_pkg::*;
#(
  parameter int NIBBLES     = NIBBLES_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       res_valid,
  input  logic [NIBBLE_W*NIBBLES-1:0] res_data,
  output logic                       res_ready,
  output logic [NIBBLE_W-1:0]        tx_nibble,
  output logic                       tx_req,
  input  logic                       tx_ack,
  output logic [3:0]                 tx_index,
  output logic                       tx_busy,
  output logic                       tx_done
);

  localparam int DATA_W = NIBBLE_W * NIBBLES;
`ifdef NIBBLE_TX_CHECKSUM_EN
  localparam int CSUM_N = 1;
`else
  localparam int CSUM_N = 0;
`endif
  localparam int SR_W = DATA_W + NIBBLE_W * CSUM_N;
  localparam logic [3:0] LAST_IDX = 4'(NIBBLES + CSUM_N - 1);

  link_state_e       state_q, state_d;
  logic [SR_W-1:0]   shift_q, shift_d;
  logic [3:0]        tx_index_q, tx_index_d;
  logic              tx_req_q, tx_req_d;
  logic              tx_busy_q, tx_busy_d;
  logic              tx_done_q, tx_done_d;
  logic              ack_s;

  nibble_link_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_in (tx_ack),
    .q_out(ack_s)
  );

`ifdef NIBBLE_TX_CHECKSUM_EN
  function automatic logic [NIBBLE_W-1:0] nib_xor(input logic [DATA_W-1:0] w);
    logic [NIBBLE_W-1:0] x;
    x = '0;
    for (int i = 0; i < NIBBLES; i++) x = x ^ w[i*NIBBLE_W +: NIBBLE_W];
    return x;
  endfunction
`endif

  assign res_ready = rst_n && (state_q == IDLE);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    tx_index_d = tx_index_q;

    case (state_q)
      IDLE: begin
        if (res_valid && res_ready) begin
          state_d    = SETUP;
          tx_index_d = '0;
`ifdef NIBBLE_TX_CHECKSUM_EN
          // Checksum rides above the data so plain shifting delivers it last.
          shift_d    = {nib_xor(res_data), res_data};
`else
          shift_d    = res_data;
`endif
        end
      end
      SETUP: begin
        if (!ack_s) state_d = REQ;
      end
      REQ: begin
        if (ack_s) state_d = RELEASE;
      end
      RELEASE: begin
        if (!ack_s) begin
          if (tx_index_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            state_d    = SETUP;
            shift_d    = shift_q >> NIBBLE_W;
            tx_index_d = tx_index_q + 4'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flops follow the next state so they line up with state_q.
    tx_req_d  = (state_d == REQ);
    tx_busy_d = (state_d == SETUP) || (state_d == REQ) || (state_d == RELEASE);
    tx_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      tx_index_q <= '0;
      tx_req_q   <= 1'b0;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      tx_index_q <= tx_index_d;
      tx_req_q   <= tx_req_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign tx_nibble = shift_q[NIBBLE_W-1:0];
  assign tx_req    = tx_req_q;
  assign tx_index  = tx_index_q;
  assign tx_busy   = tx_busy_q;
  assign tx_done   = tx_done_q;

endmodule
